// File: rtl/sbs_fixedpoint_acc_round.sv
// rtl/sbs_fixedpoint_acc_round.sv - product accumulator with half-up rounding, shift and saturation
module sbs_fixedpoint_acc_round #(
  parameter int PROD_WIDTH = 37,
  parameter int ACC_WIDTH  = 48,
  parameter int FRAC_SHIFT = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic                  prod_valid,
  input  logic [PROD_WIDTH-1:0] prod_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [ACC_WIDTH:0] HALF    = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic [ACC_WIDTH:0] OUT_MAX = {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH - 1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [LEN_WIDTH-1:0]   len;
  logic [LEN_WIDTH-1:0]   count;
  logic [LEN_WIDTH-1:0]   count_inc;
  logic                   ovf;
  logic                   accept;
  logic [ACC_WIDTH:0]     sum_ext;
  logic [ACC_WIDTH:0]     round_sum;
  logic [ACC_WIDTH:0]     round_val;
  logic                   round_sat;
  logic [OUT_WIDTH-1:0]   round_data;

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);

  assign accept    = in_ready && prod_valid;
  assign count_inc = count + LEN_ONE;
  // One extra bit exposes the carry that triggers the clamp.
  assign sum_ext   = {1'b0, acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, prod_data};

  assign round_sum  = {1'b0, acc} + HALF;
  assign round_val  = round_sum >> FRAC_SHIFT;
  assign round_sat  = (round_val > OUT_MAX);
  assign round_data = round_sat ? {OUT_WIDTH{1'b1}} : round_val[OUT_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (vec_len != '0) ? S_ACCUM : S_ROUND;
        end
      end
      S_ACCUM: begin
        if (accept && (count_inc == len)) begin
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: state_nxt = S_HOLD;
      S_HOLD: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      len      <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            len   <= vec_len;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            count <= count_inc;
            if (sum_ext[ACC_WIDTH]) begin
              acc <= {ACC_WIDTH{1'b1}};
              ovf <= 1'b1;
            end else begin
              acc <= sum_ext[ACC_WIDTH-1:0];
            end
          end
        end
        S_ROUND: begin
          out_data <= round_data;
          out_sat  <= round_sat | ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbs_fixedpoint_acc_round.sv
// tb/tb_sbs_fixedpoint_acc_round.sv - directed bench for sbs_fixedpoint_acc_round
module tb_sbs_fixedpoint_acc_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] vec_len;
  logic        prod_valid;
  logic [36:0] prod_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
  logic [15:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
  logic [15:0] out_data_b;

  int checks = 0;
  int errors = 0;
  logic seen_valid;

  localparam logic [36:0] PMAX = 37'h1F_FFFF_FFFF;

  always #5 clk = ~clk;

  sbs_fixedpoint_acc_round dut_a (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
    .prod_valid(prod_valid), .prod_data(prod_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_sat(out_sat_a), .busy(busy_a)
  );

  sbs_fixedpoint_acc_round #(.ACC_WIDTH(38)) dut_b (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
    .prod_valid(prod_valid), .prod_data(prod_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_sat(out_sat_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] len);
    start   = 1'b1;
    vec_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic feed(input logic [36:0] p);
    prod_valid = 1'b1;
    prod_data  = p;
    tick();
    prod_valid = 1'b0;
  endtask

  // Called with the DUT in ROUND: checks the 2-cycle latency, result, then releases it.
  task automatic expect_result(input string tag, input logic [15:0] da, input logic sa,
                               input logic [15:0] db, input logic sb);
    chk({tag, "_round_valid"}, out_valid_a, 1'b0);
    chk({tag, "_round_ready"}, in_ready_a, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid_a, 1'b1);
    chk({tag, "_data"}, out_data_a, da);
    chk({tag, "_sat"}, out_sat_a, sa);
    chk({tag, "_b_data"}, out_data_b, db);
    chk({tag, "_b_sat"}, out_sat_b, sb);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, out_valid_a, 1'b0);
    chk({tag, "_idle"}, busy_a, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vec_len = '0;
    prod_valid = 1'b0; prod_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready_a, 1'b0);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_out_data", out_data_a, 16'h0);
    chk("rst_out_sat", out_sat_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    reset = 1'b0;
    tick();

    // basic round 0x48000 -> 4.5 -> 5, with a stalled consumer and ignored starts
    start_run(16'd3);
    chk("basic_busy", busy_a, 1'b1);
    chk("basic_in_ready", in_ready_a, 1'b1);
    feed(37'h10000); feed(37'h20000); feed(37'h18000);
    chk("basic_round_valid", out_valid_a, 1'b0);
    tick();
    chk("basic_valid", out_valid_a, 1'b1);
    chk("basic_data", out_data_a, 16'd5);
    chk("basic_sat", out_sat_a, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start   = i[0];
      vec_len = 16'd7;
      tick();
      chk("hold_valid", out_valid_a, 1'b1);
      chk("hold_data", out_data_a, 16'd5);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("xfer_valid", out_valid_a, 1'b0);
    chk("xfer_idle", busy_a, 1'b0);

    start_run(16'd1); feed(37'h17FFF);
    expect_result("rdown", 16'd1, 1'b0, 16'd1, 1'b0);
    start_run(16'd1); feed(37'h18000);
    expect_result("rhalf", 16'd2, 1'b0, 16'd2, 1'b0);

    start_run(16'd2); feed(PMAX); feed(PMAX);
    expect_result("osat", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    start_run(16'd3); feed(PMAX); feed(PMAX); feed(PMAX);
    expect_result("clamp", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    // 2^38 exactly: a 38-bit accumulator would wrap to 0 without the clamp
    start_run(16'd3); feed(PMAX); feed(PMAX); feed(37'h2);
    expect_result("clamp_edge", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // gaps on prod_valid, start while busy must not change the latched length
    start_run(16'd2);
    start   = 1'b1;
    vec_len = 16'd5;
    tick(); tick();
    chk("gap_ready0", in_ready_a, 1'b1);
    feed(37'h8000);
    tick();
    chk("gap_ready1", in_ready_a, 1'b1);
    feed(37'h8000);
    start = 1'b0;
    expect_result("gap", 16'd1, 1'b0, 16'd1, 1'b0);

    start_run(16'd0);
    chk("zero_busy", busy_a, 1'b1);
    expect_result("zero", 16'd0, 1'b0, 16'd0, 1'b0);

    start_run(16'd4); feed(37'h30000); feed(37'h30000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_ready", in_ready_a, 1'b0);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      prod_valid = 1'b1;
      prod_data  = 37'h30000;
      tick();
      seen_valid = seen_valid | out_valid_a | busy_a;
    end
    prod_valid = 1'b0;
    chk("abort_quiet", seen_valid, 1'b0);

    start_run(16'd1); feed(37'h30000);
    expect_result("post_abort", 16'd3, 1'b0, 16'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
